ila_capture_ctrl: RTL and testbench

Capture sequencer for the internal logic analyzer sample memory. It drives the circular write pointer and write strobe while armed and counts a programmable number of post-trigger samples. It then freezes the write pointer and streams the whole buffer, oldest sample first, through the read port by pacing `read_enable` against a downstream ready. It sits between the debug host/trigger logic and the memory write/read blocks. It is the only source of `waddr`, `write_enable` and `read_enable`.

---
 rtl/ila_capture_if.sv | 31 +++
 rtl/ila_capture_ctrl.sv | 118 +++++++++++
 tb/tb_ila_capture_ctrl.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ila_capture_if.sv
// ila_capture_if: host/trigger and memory-side signals of the
// capture sequencer, bundled with host (master) and sequencer (slave) views.
interface ila_capture_if #(
  parameter int ADDR_WIDTH = 4
);
  logic                  arm;
  logic                  trigger;
  logic                  abort;
  logic [ADDR_WIDTH-1:0] post_count;
  logic                  rd_ready;
  logic                  write_enable;
  logic [ADDR_WIDTH-1:0] waddr;
  logic                  read_enable;
  logic                  sample_valid;
  logic [ADDR_WIDTH-1:0] trig_addr;
  logic                  busy;
  logic                  done;
  logic [2:0]            state;

  modport master (
    output arm, trigger, abort, post_count, rd_ready,
    input  write_enable, waddr, read_enable, sample_valid,
    input  trig_addr, busy, done, state
  );

  modport slave (
    input  arm, trigger, abort, post_count, rd_ready,
    output write_enable, waddr, read_enable, sample_valid,
    output trig_addr, busy, done, state
  );
endinterface

// File: rtl/ila_capture_ctrl.sv
// ila_capture_ctrl: ILA capture sequencer (circular write, post-trigger
// count, oldest-first readout). Option macro: ILA_PRETRIG_FILL_EN.
module ila_capture_ctrl #(
  parameter int ADDR_WIDTH = 4
) (
  input logic         clk,
  input logic         reset,
  ila_capture_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARMED   = 3'd1,
    S_POST    = 3'd2,
    S_READY   = 3'd3,
    S_READOUT = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [ADDR_WIDTH-1:0] r_waddr;
  logic [ADDR_WIDTH-1:0] r_trig_addr;
  logic [ADDR_WIDTH-1:0] r_post_len;
  logic [CW-1:0]         r_post_cnt;
  logic [CW-1:0]         r_rd_cnt;
  logic                  r_we;
  logic                  r_done;
  logic [1:0]            r_sv;
  logic                  w_re;
  logic                  w_last_rd;
  logic                  w_fill_ok;
  logic                  w_trig_ok;
  logic                  w_arm_ok;

`ifdef ILA_PRETRIG_FILL_EN
  logic [CW-1:0] r_fill_cnt;
  logic [CW-1:0] w_fill_need;

  assign w_fill_need = CW'(DEPTH - 1) - {1'b0, r_post_len};
  assign w_fill_ok   = (r_fill_cnt >= w_fill_need);

  // count samples written since arm so trigger waits for a full buffer
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fill_cnt <= '0;
    end else if (w_arm_ok) begin
      r_fill_cnt <= '0;
    end else if (r_state == S_ARMED && r_we && r_fill_cnt != '1) begin
      r_fill_cnt <= r_fill_cnt + 1'b1;
    end
  end
`else
  assign w_fill_ok = 1'b1;
`endif

  assign w_arm_ok  = (r_state == S_IDLE) && bus.arm && !bus.abort;
  assign w_trig_ok = (r_state == S_ARMED) && bus.trigger &&
                     w_fill_ok && !bus.abort;
  assign w_re      = (r_state == S_READOUT) && bus.rd_ready &&
                     !bus.abort && !reset;
  assign w_last_rd = w_re && (r_rd_cnt == CW'(DEPTH - 1));

  // next-state selection; abort overrides everything
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:    if (bus.arm) w_next = S_ARMED;
      S_ARMED:   if (w_trig_ok)
                   w_next = (r_post_len == '0) ? S_READY : S_POST;
      S_POST:    if (r_post_cnt == CW'(1)) w_next = S_READY;
      S_READY:   w_next = S_READOUT;
      S_READOUT: if (w_last_rd) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
    if (bus.abort) w_next = S_IDLE;
  end

  // state, write pointer, counters and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_we        <= 1'b0;
      r_waddr     <= '0;
      r_trig_addr <= '0;
      r_post_len  <= '0;
      r_post_cnt  <= '0;
      r_rd_cnt    <= '0;
      r_sv        <= '0;
      r_done      <= 1'b0;
    end else begin
      r_state <= w_next;
      r_we    <= (w_next == S_ARMED) || (w_next == S_POST);
      if (r_we) r_waddr <= r_waddr + 1'b1;
      if (w_arm_ok) r_post_len <= bus.post_count;
      if (w_trig_ok) begin
        r_trig_addr <= r_waddr;
        r_post_cnt  <= {1'b0, r_post_len};
      end else if (r_state == S_POST) begin
        r_post_cnt <= r_post_cnt - 1'b1;
      end
      if (r_state == S_READY) r_rd_cnt <= '0;
      else if (w_re) r_rd_cnt <= r_rd_cnt + 1'b1;
      r_sv   <= {r_sv[0], w_re};
      r_done <= w_last_rd;
    end
  end

  assign bus.write_enable = r_we;
  assign bus.waddr        = r_waddr;
  assign bus.read_enable  = w_re;
  assign bus.sample_valid = r_sv[1];
  assign bus.trig_addr    = r_trig_addr;
  assign bus.busy         = (r_state != S_IDLE);
  assign bus.done         = r_done;
  assign bus.state        = r_state;
endmodule

// File: tb/tb_ila_capture_ctrl.sv
// tb_ila_capture_ctrl: directed bench for ila_capture_ctrl with a
// per-cycle reference model and readout-order scoreboard.
module tb_ila_capture_ctrl;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  ila_capture_if #(.ADDR_WIDTH(AW)) bus ();

  ila_capture_ctrl #(.ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // reference model: phase 0 idle, 1 armed, 2 post, 3 ready, 4 readout
  int m_ph, m_waddr, m_trig, m_left, m_reads, m_fill, m_pc, m_freeze;
  bit m_we, m_done, m_sv1, m_sv2;

  always @(posedge clk) begin : model
    bit re;
    bit fok;
    int nph;
    int wa_old;
    if (reset) begin
      m_ph = 0; m_waddr = 0; m_trig = 0; m_left = 0;
      m_reads = 0; m_fill = 0; m_pc = 0; m_freeze = 0;
      m_we = 0; m_done = 0; m_sv1 = 0; m_sv2 = 0;
    end else begin
      re = (m_ph == 4) && bus.rd_ready && !bus.abort;
`ifdef ILA_PRETRIG_FILL_EN
      fok = (m_fill >= DEPTH - 1 - m_pc);
`else
      fok = 1'b1;
`endif
      wa_old = m_waddr;
      m_sv2  = m_sv1;
      m_sv1  = re;
      m_done = re && (m_reads == DEPTH - 1);
      if (m_we) m_waddr = (m_waddr + 1) % DEPTH;
      nph = m_ph;
      if (bus.abort) begin
        nph = 0;
      end else if (m_ph == 0) begin
        if (bus.arm) begin
          m_pc = int'(bus.post_count); m_fill = 0; nph = 1;
        end
      end else if (m_ph == 1) begin
        if (bus.trigger && fok) begin
          m_trig = wa_old; m_left = m_pc;
          nph = (m_pc == 0) ? 3 : 2;
        end
        m_fill++;
      end else if (m_ph == 2) begin
        m_left--;
        if (m_left == 0) nph = 3;
      end else if (m_ph == 3) begin
        nph = 4;
      end else begin
        if (re) m_reads++;
        if (m_reads == DEPTH) nph = 0;
      end
      if (nph == 3) begin
        m_freeze = m_waddr; m_reads = 0;
      end
      m_we = (nph == 1) || (nph == 2);
      m_ph = nph;
    end
  end

  // observation counters and readout scoreboard
  int q[$];
  int n_rd_idx, n_sv, n_re, n_done, n_wr_trig, n_armed_wr;
  int first_addr, last_addr;

  always @(negedge clk) begin : compare
    bit re_e;
    int idx;
    if (chk_en) begin
      re_e = (m_ph == 4) && bus.rd_ready && !bus.abort && !reset;
      chk("state", bus.state, m_ph);
      chk("write_enable", bus.write_enable, m_we);
      chk("waddr", bus.waddr, m_waddr);
      chk("read_enable", bus.read_enable, re_e);
      chk("sample_valid", bus.sample_valid, m_sv2);
      chk("trig_addr", bus.trig_addr, m_trig);
      chk("busy", bus.busy, m_ph != 0);
      chk("done", bus.done, m_done);
      if (reset) begin
        q.delete(); n_rd_idx = 0; n_sv = 0;
      end else begin
        if (bus.state == 3'd3) begin
          n_rd_idx = 0; n_sv = 0;
        end
        if (bus.sample_valid) begin
          if (q.size() == 0) begin
            chk("sv_without_read", 1, 0);
          end else begin
            idx = q.pop_front();
            chk("rd_order", idx, n_sv);
            last_addr = (m_freeze + idx) % DEPTH;
            if (n_sv == 0) first_addr = last_addr;
            n_sv++;
          end
        end
        if (bus.read_enable) begin
          q.push_back(n_rd_idx); n_rd_idx++; n_re++;
        end
        if (bus.done) n_done++;
        if (bus.write_enable) n_wr_trig++;
        if (bus.write_enable && bus.state == 3'd1) n_armed_wr++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input int s, input int budget, input string nm);
    for (int i = 0; i < budget; i++) begin
      if (int'(bus.state) == s) return;
      step();
    end
    chk(nm, bus.state, s);
  endtask

  task automatic run_readout(input bit toggle);
    n_re = 0;
    n_done = 0;
    for (int i = 0; i < 200; i++) begin
      bus.rd_ready = toggle ? !bus.rd_ready : 1'b1;
      step();
      if (n_done != 0) break;
    end
    bus.rd_ready = 1'b0;
    repeat (3) step();
    if (n_done == 0) chk("readout_timeout", 0, 1);
  endtask

  task automatic capture(input int pc, input int gap);
    bus.post_count = AW'(pc);
    bus.arm = 1'b1;
    step();
    bus.arm = 1'b0;
    repeat (gap) step();
    n_wr_trig = 0;
    bus.trigger = 1'b1;
    step();
    bus.trigger = 1'b0;
  endtask

  initial begin
    bus.arm = 0; bus.trigger = 0; bus.abort = 0;
    bus.post_count = '0; bus.rd_ready = 0;
    step();
    chk_en = 1;
    step();
    reset = 0;

    // idle with trigger high and no arm
    bus.trigger = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("idle_we", bus.write_enable, 0);
      chk("idle_busy", bus.busy, 0);
      chk("idle_waddr", bus.waddr, 0);
    end
    bus.trigger = 1'b0;

    // post_count 5, trigger 20 cycles after arm
    capture(5, 19);
    chk("trig_addr_lit", bus.trig_addr, 3);
    wait_state(3, 20, "reach_ready_a");
    chk("writes_from_trig", n_wr_trig, 6);
    chk("freeze_waddr", bus.waddr, 9);
    run_readout(1'b1);
    chk("rd_pulses", n_re, 16);
    chk("sv_count", n_sv, 16);
    chk("done_once", n_done, 1);
    chk("first_addr", first_addr, 9);
    chk("last_addr", last_addr, 8);
    chk("idle_after", bus.busy, 0);

    // post_count 0
    capture(0, 19);
    chk("pc0_ready_next", bus.state, 3);
    chk("pc0_writes", n_wr_trig, 1);
    chk("pc0_trig_addr", bus.trig_addr, 12);
    run_readout(1'b0);
    chk("pc0_rd_pulses", n_re, 16);
    chk("pc0_done", n_done, 1);
    chk("pc0_first", first_addr, 13);

    // trigger held from arm, then abort mid-POST
    bus.post_count = AW'(5);
    n_armed_wr = 0;
    bus.trigger = 1'b1;
    bus.arm = 1'b1;
    step();
    bus.arm = 1'b0;
    wait_state(2, 40, "reach_post");
    bus.trigger = 1'b0;
`ifdef ILA_PRETRIG_FILL_EN
    chk("accept_write", n_armed_wr, 11);
`else
    chk("accept_write", n_armed_wr, 1);
`endif
    step();
    n_done = 0;
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    chk("abort_state", bus.state, 0);
    chk("abort_we", bus.write_enable, 0);
    repeat (5) step();
    chk("abort_no_done", n_done, 0);

    // reset mid-readout, then a fresh capture
    capture(3, 5);
    wait_state(4, 20, "reach_readout");
    bus.rd_ready = 1'b1;
    repeat (6) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus.rd_ready = 1'b0;
    chk("rst_state", bus.state, 0);
    chk("rst_waddr", bus.waddr, 0);
    capture(2, 7);
    chk("fresh_trig_addr", bus.trig_addr, 7);
    wait_state(3, 20, "reach_ready_b");
    chk("fresh_freeze", bus.waddr, 10);
    run_readout(1'b1);
    chk("fresh_rd_pulses", n_re, 16);
    chk("fresh_sv", n_sv, 16);
    chk("fresh_first", first_addr, 10);
    chk("fresh_last", last_addr, 9);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
